// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides, barrel
// shifter/rotator, NZCV flags and a sideband tag that follows each operation.
`ifndef ALU_REG_WIDTH
`define ALU_REG_WIDTH 16
`endif

module alu_pipe #(
  parameter int REG_WIDTH = `ALU_REG_WIDTH,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           instr_i,
  input  logic [REG_WIDTH-1:0] a_i,
  input  logic [REG_WIDTH-1:0] b_i,
  input  logic                 cin_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] acc_o,
  output logic                 cout_o,
  output logic [3:0]           flags_o,
  output logic                 err_o,
  output logic [TAG_WIDTH-1:0] tag_o
);
  localparam int SHW = $clog2(REG_WIDTH);
  localparam logic [SHW:0] WIDTH_C = (SHW+1)'(REG_WIDTH);

  localparam logic [3:0] OP_NOT  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XNOR = 4'h8;
  localparam logic [3:0] OP_RSH  = 4'h9;
  localparam logic [3:0] OP_LSH  = 4'hA;
  localparam logic [3:0] OP_RRO  = 4'hB;
  localparam logic [3:0] OP_LRO  = 4'hC;

  logic                 s1_valid;
  logic [REG_WIDTH-1:0] s1_res;
  logic                 s1_cout;
  logic                 s1_err;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic                 s1_arith;
  logic                 s1_sign_a;
  logic                 s1_sign_b;

  logic                 s2_adv;
  logic                 s1_adv;
  logic                 accept;

  logic [SHW-1:0]       shamt;
  logic [SHW:0]         rot_comp;
  logic [REG_WIDTH-1:0] b_eff;
  logic [REG_WIDTH:0]   sum;
  logic [REG_WIDTH:0]   rsh_ext;
  logic [REG_WIDTH:0]   lsh_ext;
  logic [REG_WIDTH-1:0] rotr;
  logic [REG_WIDTH-1:0] rotl;
  logic [REG_WIDTH-1:0] res;
  logic                 res_cout;
  logic                 res_err;
  logic                 is_arith;
  logic                 s1_ovf;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !flush_i;
  assign accept   = in_valid && in_ready;

  // A guard bit on each side of the operand captures the last bit shifted out.
  assign shamt    = b_i[SHW-1:0];
  assign rot_comp = WIDTH_C - {1'b0, shamt};
  assign is_arith = (instr_i == OP_ADD) || (instr_i == OP_SUB);
  assign b_eff    = (instr_i == OP_SUB) ? ~b_i : b_i;
  assign sum      = {1'b0, a_i} + {1'b0, b_eff} + {{REG_WIDTH{1'b0}}, cin_i};
  assign rsh_ext  = {a_i, 1'b0} >> shamt;
  assign lsh_ext  = {1'b0, a_i} << shamt;
  assign rotr     = (a_i >> shamt) | (a_i << rot_comp);
  assign rotl     = (a_i << shamt) | (a_i >> rot_comp);

  // Opcode decode and result/carry selection for the accepted request.
  always_comb begin
    res      = '0;
    res_cout = 1'b0;
    res_err  = 1'b0;
    case (instr_i)
      OP_NOT:  res = ~a_i;
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_ADD, OP_SUB: begin
        res      = sum[REG_WIDTH-1:0];
        res_cout = sum[REG_WIDTH];
      end
      OP_NAND: res = ~(a_i & b_i);
      OP_NOR:  res = ~(a_i | b_i);
      OP_XNOR: res = ~(a_i ^ b_i);
      OP_RSH: begin
        res      = rsh_ext[REG_WIDTH:1];
        res_cout = rsh_ext[0];
      end
      OP_LSH: begin
        res      = lsh_ext[REG_WIDTH-1:0];
        res_cout = lsh_ext[REG_WIDTH];
      end
      OP_RRO:  res = rotr;
      OP_LRO:  res = rotl;
      default: res_err = 1'b1;
    endcase
  end

  // Stage 1: capture result and the operand signs needed for overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_res    <= '0;
      s1_cout   <= 1'b0;
      s1_err    <= 1'b0;
      s1_tag    <= '0;
      s1_arith  <= 1'b0;
      s1_sign_a <= 1'b0;
      s1_sign_b <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_res    <= res;
        s1_cout   <= res_cout;
        s1_err    <= res_err;
        s1_tag    <= tag_i;
        s1_arith  <= is_arith;
        s1_sign_a <= a_i[REG_WIDTH-1];
        s1_sign_b <= b_eff[REG_WIDTH-1];
      end
    end
  end

  assign s1_ovf = s1_arith && (s1_sign_a == s1_sign_b) &&
                  (s1_res[REG_WIDTH-1] != s1_sign_a);

  // Stage 2: output registers; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      acc_o     <= '0;
      cout_o    <= 1'b0;
      flags_o   <= 4'b0000;
      err_o     <= 1'b0;
      tag_o     <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        acc_o   <= s1_res;
        cout_o  <= s1_cout;
        flags_o <= s1_err ? 4'b0000
                          : {s1_res[REG_WIDTH-1], (s1_res == '0), s1_cout, s1_ovf};
        err_o   <= s1_err;
        tag_o   <= s1_tag;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: arithmetic scoreboard model plus directed
// vectors for arithmetic, shifts, stalls, flush, undefined opcodes and reset.
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        reset, flush_i, in_valid, in_ready, cin_i;
  logic        out_valid, out_ready, cout_o, err_o;
  logic [3:0]  instr_i, tag_i, tag_o, flags_o;
  logic [15:0] a_i, b_i, acc_o;

  int checks = 0;
  int passed = 0;
  int cycle  = 0;
  logic [25:0] exp_q[$];
  logic [3:0]  pop_tags[$];
  int          pop_cycles[$];
  logic        hold_pending = 1'b0;
  logic [25:0] held;

  alu_pipe #(.REG_WIDTH(16), .TAG_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid(in_valid),
    .in_ready(in_ready), .instr_i(instr_i), .a_i(a_i), .b_i(b_i),
    .cin_i(cin_i), .tag_i(tag_i), .out_valid(out_valid), .out_ready(out_ready),
    .acc_o(acc_o), .cout_o(cout_o), .flags_o(flags_o), .err_o(err_o),
    .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Result packed as {acc[15:0], cout, flags N Z C V, err, tag}.
  function automatic logic [25:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin,
                                        input logic [3:0] tag);
    logic [15:0] r;
    logic c, v, e;
    logic [3:0] f;
    int s, si, n;
    r = 16'h0; c = 1'b0; v = 1'b0; e = 1'b0;
    n = int'(b) % 16;
    case (op)
      4'h0: r = ~a;
      4'h1: r = a & b;
      4'h2: r = a | b;
      4'h3: r = a ^ b;
      4'h4: begin
        s  = int'(a) + int'(b) + int'(cin);
        r  = 16'(s);
        c  = (s > 65535);
        si = int'($signed(a)) + int'($signed(b)) + int'(cin);
        v  = (si > 32767) || (si < -32768);
      end
      4'h5: begin
        s  = int'(a) + (65535 - int'(b)) + int'(cin);
        r  = 16'(s);
        c  = (s > 65535);
        si = int'($signed(a)) - int'($signed(b)) - 1 + int'(cin);
        v  = (si > 32767) || (si < -32768);
      end
      4'h6: r = ~(a & b);
      4'h7: r = ~(a | b);
      4'h8: r = ~(a ^ b);
      4'h9: begin
        r = a >> n;
        if (n > 0) c = a[n-1];
      end
      4'hA: begin
        r = a << n;
        if (n > 0) c = a[16-n];
      end
      4'hB: begin
        r = a;
        for (int i = 0; i < n; i++) r = {r[0], r[15:1]};
      end
      4'hC: begin
        r = a;
        for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
      end
      default: e = 1'b1;
    endcase
    f = e ? 4'b0000 : {r[15], (r == 16'h0), c, v};
    return {r, c, f, e, tag};
  endfunction

  // Scoreboard bookkeeping at the active edge: retire, then enqueue.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (reset || flush_i) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        pop_tags.push_back(tag_o);
        pop_cycles.push_back(cycle);
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(instr_i, a_i, b_i, cin_i, tag_i));
    end
  end

  // Compare outputs mid-cycle against the model and the stall-hold rule.
  always @(negedge clk) begin
    if (hold_pending)
      check("stall_hold", {acc_o, cout_o, flags_o, err_o, tag_o}, held);
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
      else check("scoreboard", {acc_o, cout_o, flags_o, err_o, tag_o}, exp_q[0]);
    end
    hold_pending <= out_valid && !out_ready && !flush_i && !reset;
    held         <= {acc_o, cout_o, flags_o, err_o, tag_o};
  end

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [3:0] tag);
    instr_i = op; a_i = a; b_i = b; cin_i = cin; tag_i = tag; in_valid = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [3:0] tag);
    logic acc;
    int n;
    drive(op, a, b, cin, tag);
    #1;
    n = 0;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    check("accepted", {31'b0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_one(input string name, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin, input logic [15:0] e_acc,
                         input logic e_cout, input logic [3:0] e_flags, input logic e_err);
    issue(op, a, b, cin, 4'h9);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check(name, {acc_o, cout_o, flags_o, err_o, tag_o}, {e_acc, e_cout, e_flags, e_err, 4'h9});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] sops[6];
    logic acc;
    int idx;
    sops = '{4'h4, 4'h5, 4'h3, 4'hA, 4'hB, 4'h7};
    reset = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr_i = 4'h0; a_i = 16'h0; b_i = 16'h0; cin_i = 1'b0; tag_i = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("reset_state", {out_valid, acc_o, cout_o, flags_o, err_o, tag_o, in_ready},
          {1'b0, 16'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1});

    check("model_add_wrap", model(4'h4, 16'hFFFF, 16'h0001, 1'b0, 4'h0),
          {16'h0000, 1'b1, 4'b0110, 1'b0, 4'h0});
    check("model_rro", model(4'hB, 16'h0003, 16'h0001, 1'b0, 4'h0),
          {16'h8001, 1'b0, 4'b1000, 1'b0, 4'h0});
    check("model_sub_borrow", model(4'h5, 16'h0003, 16'h0005, 1'b1, 4'h0),
          {16'hFFFE, 1'b0, 4'b1000, 1'b0, 4'h0});

    run_one("add_wrap", 4'h4, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b0110, 1'b0);
    run_one("add_ovf",  4'h4, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 4'b1001, 1'b0);
    run_one("sub_pos",  4'h5, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 4'b0010, 1'b0);
    run_one("sub_neg",  4'h5, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 4'b1000, 1'b0);
    run_one("rsh_1",    4'h9, 16'h8001, 16'h0011, 1'b0, 16'h4000, 1'b1, 4'b0010, 1'b0);
    run_one("lro_4",    4'hC, 16'h8001, 16'h0004, 1'b0, 16'h0018, 1'b0, 4'b0000, 1'b0);
    run_one("lsh_0",    4'hA, 16'hA5A5, 16'h0010, 1'b0, 16'hA5A5, 1'b0, 4'b1000, 1'b0);
    run_one("undef_e",  4'hE, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 4'b0000, 1'b1);
    idle(2);

    // Six back-to-back ops with the consumer stalled on cycles 2..5.
    pop_tags.delete(); pop_cycles.delete();
    idx = 0;
    for (int cyc = 0; cyc < 40 && (idx < 6 || pop_tags.size() < 6); cyc++) begin
      out_ready = (cyc >= 2 && cyc <= 5) ? 1'b0 : 1'b1;
      if (idx < 6) drive(sops[idx], 16'(16'h1357 * (idx + 1)), 16'(idx + 3), idx[0], 4'(idx));
      else in_valid = 1'b0;
      #1;
      if (cyc == 2) begin
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        check("stall_accepts", idx, 2);
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    check("stream_count", pop_tags.size(), 6);
    if (pop_tags.size() == 6) begin
      for (int i = 0; i < 6; i++) check("stream_tag_order", pop_tags[i], i);
      for (int i = 1; i < 6; i++) check("stream_gap", pop_cycles[i] - pop_cycles[i-1], 1);
    end
    idle(2);

    // Fill both stages, then flush.
    out_ready = 1'b0;
    issue(4'h1, 16'hF0F0, 16'h3C3C, 1'b0, 4'h1);
    issue(4'h2, 16'hF0F0, 16'h3C3C, 1'b0, 4'h2);
    drive(4'h3, 16'h1111, 16'h2222, 1'b0, 4'h3);
    flush_i = 1'b1;
    #1;
    check("flush_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    run_one("post_flush", 4'h8, 16'hFF00, 16'h0FF0, 1'b0, 16'h0F0F, 1'b0, 4'b0000, 1'b0);
    idle(2);

    // Reset with both stages full.
    out_ready = 1'b0;
    issue(4'h4, 16'h0101, 16'h0202, 1'b0, 4'h5);
    issue(4'h0, 16'h00FF, 16'h0000, 1'b0, 4'h6);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("reset_mid", {out_valid, acc_o, cout_o, flags_o, err_o, tag_o, in_ready},
          {1'b0, 16'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1});
    out_ready = 1'b1;
    run_one("post_reset", 4'hB, 16'h0003, 16'h0001, 1'b0, 16'h8001, 1'b0, 4'b1000, 1'b0);
    idle(3);
    check("drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Two-stage pipelined ALU with a valid/ready handshake on both sides, a full barrel shifter, condition flags and a tag that travels with each operation. It is the parametrised successor to the single-cycle ALU and sits between the issue stage and the writeback/reorder logic. The issue stage can stall it without losing operations, and can also flush it. Supports all 13 architectural opcodes and reports undefined opcodes as errors.

## Interface
- REG_WIDTH, default `ALU_REG_WIDTH` (from `projectConfig/alu_parameters.sv`): operand and result width; must be a power of 2 and at least 4.
- TAG_WIDTH, default 4: width of the sideband tag; the block does not interpret it.
- SHW, derived as $clog2(REG_WIDTH): width of the shift-amount field; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous; drops every in-flight operation.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- instr_i  in  4  opcode.
- a_i  in  REG_WIDTH  operand A.
- b_i  in  REG_WIDTH  operand B; for shifts, the amount is b_i[SHW-1:0].
- cin_i  in  1  carry in.
- tag_i  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- acc_o  out  REG_WIDTH  result.
- cout_o  out  1  carry out.
- flags_o  out  4  {N, Z, C, V}.
- err_o  out  1  undefined opcode.
- tag_o  out  TAG_WIDTH  tag of the result.

## Operation
- A request is accepted on a rising edge where in_valid && in_ready.
- Opcodes:
  - 0 NOT: ~a.
  - 1 AND, 2 OR, 3 XOR: bitwise a with b.
  - 4 ADD: a+b+cin.
  - 5 SUB: a+~b+cin. cin=1 means no borrow; cout=1 means no borrow.
  - 6 NAND, 7 NOR, 8 XNOR: bitwise.
  - 9 RSH: logical right shift.
  - A LSH: logical left shift.
  - B RRO: rotate right.
  - C LRO: rotate left.
  - D/E/F: acc=0, cout=0, flags=0, err_o=1.
- cout:
  - ADD/SUB: carry out of bit REG_WIDTH-1.
  - RSH/LSH: the last bit shifted out; 0 when the amount is 0.
  - All other opcodes: 0.
- Flags:
  - N = acc[REG_WIDTH-1].
  - Z = (acc==0).
  - C = cout.
  - V = signed overflow for ADD/SUB only; 0 for every other opcode.
- Stage split:
  - Stage 1 registers the result, cout, err, tag and the operand sign bits needed for V.
  - Stage 2 registers acc_o, cout_o, flags_o, err_o and tag_o.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !flush_i. This is a combinational ready chain; no skid buffer.
- Stall:
  - While out_valid && !out_ready, every output holds stable.
  - Stage 1 holds if it is occupied.
  - in_ready drops only when both stages are full.
- The opcode is not decoded until acceptance; in_valid must not depend on in_ready.

## Timing
- Latency is 2: a request accepted on edge k produces out_valid=1 after edge k+1, with no stall.
- Throughput is 1 operation per cycle when out_ready is held high.
- Capacity is 2 in-flight operations. Results come out in order; none are dropped or duplicated.
- Reset (edge with reset=1):
  - s1_valid and s2_valid go to 0.
  - out_valid=0, acc_o=0, cout_o=0, flags_o=0, err_o=0, tag_o=0.
  - in_ready=1 in the first cycle after reset.
- Flush (edge with flush_i=1):
  - Both valids clear; data registers may keep stale values.
  - in_ready=0 during the flush cycle, so no request is accepted on that edge.
  - out_ready is ignored on that edge, so a result presented in that cycle is lost.
- reset has priority over flush_i.
- Simultaneous events: on one edge stage 2 may drain, stage 1 may advance and a new request may be accepted. With both stages full and out_ready=1, in_ready=1 in that same cycle.
- Widths:
  - Shift amounts use only b[SHW-1:0]; upper bits of b are ignored.
  - An amount of 0 passes a through unchanged.
  - Adder carry is computed at REG_WIDTH+1 bits.

## Test plan
- REG_WIDTH=16, out_ready=1. ADD a=0xFFFF, b=0x0001, cin=0 → two cycles later acc=0x0000, cout=1, flags=0110.
- ADD a=0x7FFF, b=0x0001, cin=0 → acc=0x8000, flags=1001 (N=1, V=1).
- SUB a=5, b=3, cin=1 → acc=2, cout=1.
- SUB a=3, b=5, cin=1 → acc=0xFFFE, cout=0, N=1.
- Shifts:
  - RSH a=0x8001, b=0x0011 (amount 1) → acc=0x4000, cout=1.
  - LRO a=0x8001, b=4 → acc=0x0018, cout=0.
- Stream 6 back-to-back ops, tags 0..5, with out_ready held low for cycles 2–5. Required:
  - in_ready drops after 2 accepts.
  - Outputs hold stable during the stall.
  - Results emerge in tag order 0..5 with no gaps once released.
- Fill both stages and assert flush_i for one cycle → out_valid=0 next cycle, in_ready=0 during the flush cycle. A new op issued after the flush returns correctly two cycles later.
- instr_i=0xE → err_o=1, acc=0.
- Assert reset mid-stream with both stages full → the next cycle has out_valid=0, all outputs 0 and in_ready=1.
